// File: rtl/stream_fifo_ram_ctrl_pkg.sv
// Shared sizing helpers for the RAM-backed stream FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
package stream_fifo_ram_ctrl_pkg;

  localparam int unsigned OutBufDepth = 2;

  function automatic int unsigned addr_width(int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned ptr_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/Ram_1w_1rs.sv
// One-write / one-read synchronous RAM with per-lane write mask and registered read.
// Read-under-write to the same address returns undefined data.
module Ram_1w_1rs #(
  parameter int unsigned wordCount   = 16,
  parameter int unsigned wordWidth   = 32,
  parameter int unsigned wrMaskWidth = 1,
  parameter int unsigned addrWidth   = $clog2(wordCount)
) (
  input  logic                   wr_clk,
  input  logic                   wr_en,
  input  logic [wrMaskWidth-1:0] wr_mask,
  input  logic [addrWidth-1:0]   wr_addr,
  input  logic [wordWidth-1:0]   wr_data,
  input  logic                   rd_clk,
  input  logic                   rd_en,
  input  logic [addrWidth-1:0]   rd_addr,
  output logic [wordWidth-1:0]   rd_data
);

  localparam int unsigned LaneWidth = wordWidth / wrMaskWidth;

  logic [wordWidth-1:0] mem [wordCount];

  always_ff @(posedge wr_clk) begin
    for (int unsigned i = 0; i < wrMaskWidth; i++) begin
      if (wr_en && wr_mask[i]) begin
        mem[wr_addr][i*LaneWidth +: LaneWidth] <= wr_data[i*LaneWidth +: LaneWidth];
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/stream_fifo_ram_ctrl.sv
// Valid/ready FIFO storing entries in a synchronous RAM, with a 2-entry output
// buffer that hides the 1-cycle read latency so one push and one pop per cycle are sustained.
module stream_fifo_ram_ctrl
  import stream_fifo_ram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [WIDTH-1:0]             push_payload,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [WIDTH-1:0]             pop_payload,
  input  logic                         flush,
  output logic [ptr_width(DEPTH)-1:0]  occupancy
);

  localparam int unsigned AW = addr_width(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] FullCount = PW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, occ_q, ram_count;
  logic [1:0]       out_count_q, out_count_d;
  logic             rd_pending_q;
  logic [WIDTH-1:0] buf_q [OutBufDepth];
  logic [WIDTH-1:0] buf_d [OutBufDepth];
  logic [WIDTH-1:0] rd_data;
  logic             push_fire, pop_fire, rd_issue;
  logic [2:0]       rd_slots;

  // ram_count excludes this cycle's write, so a read never targets the word being written.
  assign ram_count   = wr_ptr_q - rd_ptr_q;
  assign push_ready  = (occ_q != FullCount) && !flush;
  assign push_fire   = push_valid && push_ready;
  assign pop_valid   = (out_count_q != 2'd0);
  assign pop_fire    = pop_valid && pop_ready;
  assign pop_payload = buf_q[0];
  assign occupancy   = occ_q;

  // Buffer slots already claimed after this cycle's pop, counting the read in flight.
  assign rd_slots = {1'b0, out_count_q} + {2'b00, rd_pending_q} - {2'b00, pop_fire};
  assign rd_issue = (ram_count != '0) && (rd_slots < 3'd2);

  always_comb begin
    buf_d       = buf_q;
    out_count_d = out_count_q;
    if (pop_fire) begin
      buf_d[0]    = buf_q[1];
      out_count_d = out_count_q - 2'd1;
    end
    if (rd_pending_q) begin
      if (out_count_d == 2'd0) begin
        buf_d[0] = rd_data;
      end else begin
        buf_d[1] = rd_data;
      end
      out_count_d = out_count_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_count_q  <= '0;
      rd_pending_q <= 1'b0;
      occ_q        <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_issue) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      rd_pending_q <= rd_issue;
      out_count_q  <= out_count_d;
      case ({push_fire, pop_fire})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Payload storage needs no reset; out_count_q qualifies it.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  Ram_1w_1rs #(
    .wordCount  (DEPTH),
    .wordWidth  (WIDTH),
    .wrMaskWidth(1)
  ) u_ram (
    .wr_clk (clk),
    .wr_en  (push_fire),
    .wr_mask(1'b1),
    .wr_addr(wr_ptr_q[AW-1:0]),
    .wr_data(push_payload),
    .rd_clk (clk),
    .rd_en  (rd_issue),
    .rd_addr(rd_ptr_q[AW-1:0]),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_stream_fifo_ram_ctrl.sv
// Self-checking bench: a queue model with per-entry push stamps predicts every output each cycle.
module tb_stream_fifo_ram_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned PW    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             push_valid = 1'b0;
  logic             push_ready;
  logic [WIDTH-1:0] push_payload = '0;
  logic             pop_valid;
  logic             pop_ready = 1'b0;
  logic [WIDTH-1:0] pop_payload;
  logic             flush = 1'b0;
  logic [PW-1:0]    occupancy;

  stream_fifo_ram_ctrl #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_payload(push_payload),
    .pop_valid   (pop_valid),
    .pop_ready   (pop_ready),
    .pop_payload (pop_payload),
    .flush       (flush),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int unsigned      stamp;
  } entry_t;

  entry_t      mq[$];
  int unsigned edge_cnt = 0;
  bit          armed = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // An entry accepted at edge N is visible once edge N+2 has passed.
  function automatic bit m_pop_valid();
    return (mq.size() > 0) && (edge_cnt >= mq[0].stamp + 2);
  endfunction

  function automatic bit m_push_ready();
    return (mq.size() != DEPTH) && !flush;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge using the inputs held during the cycle.
  initial begin
    forever begin
      bit pv, pr;
      @(posedge clk);
      pv = m_pop_valid();
      pr = m_push_ready();
      if (reset) begin
        armed = 1'b1;
        mq.delete();
      end else if (flush) begin
        mq.delete();
      end else begin
        if (pv && pop_ready) void'(mq.pop_front());
        if (push_valid && pr) mq.push_back('{data: push_payload, stamp: edge_cnt + 1});
      end
      edge_cnt++;
    end
  end

  // Compare every output against the model mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("push_ready", push_ready, m_push_ready());
        check("pop_valid", pop_valid, m_pop_valid());
        check("occupancy", occupancy, mq.size());
        if (m_pop_valid()) check("pop_payload", pop_payload, mq[0].data);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] exp_vals[$];
    int npop, pushed, popped;
    bit stalled;
    logic [WIDTH-1:0] held;

    cycle();
    cycle();
    reset = 1'b0;
    check("reset_push_ready", push_ready, 1);
    check("reset_pop_valid", pop_valid, 0);
    check("reset_occupancy", occupancy, 0);

    // Single entry latency through an empty FIFO.
    pop_ready = 1'b1;
    push_valid = 1'b1;
    push_payload = 32'hA0;
    cycle();
    push_valid = 1'b0;
    check("lat_n0_pop_valid", pop_valid, 0);
    cycle();
    check("lat_n1_pop_valid", pop_valid, 0);
    cycle();
    check("lat_n2_pop_valid", pop_valid, 1);
    check("lat_n2_payload", pop_payload, 32'hA0);
    cycle();
    check("lat_occ_zero", occupancy, 0);

    // Fill to full, refuse a ninth, drain in order.
    pop_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push_valid = 1'b1;
      push_payload = WIDTH'(i);
      cycle();
    end
    check("full_push_ready", push_ready, 0);
    check("full_occupancy", occupancy, 8);
    push_payload = 32'd9;
    cycle();
    check("full_refuse_occ", occupancy, 8);
    push_valid = 1'b0;
    pop_ready = 1'b1;
    got.delete();
    for (int g = 0; g < 40 && got.size() < 8; g++) begin
      if (pop_valid) got.push_back(pop_payload);
      cycle();
    end
    check("drain_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check("drain_order", got[i], i + 1);
    check("drain_occ", occupancy, 0);

    // Continuous streaming: one pop per cycle after priming.
    npop = 0;
    for (int i = 0; i < 100; i++) begin
      push_valid = 1'b1;
      push_payload = WIDTH'(i);
      if (pop_valid) begin
        check("stream_order", pop_payload, npop);
        npop++;
      end
      cycle();
    end
    push_valid = 1'b0;
    check("stream_pops", npop, 97);
    check("stream_occ", occupancy, 3);
    repeat (6) cycle();

    // Random push/pop with stalls across 500 entries.
    pushed = 0;
    popped = 0;
    stalled = 1'b0;
    held = '0;
    for (int g = 0; g < 8000 && popped < 500; g++) begin
      if (stalled && pop_valid) check("stall_stable", pop_payload, held);
      push_valid = (pushed < 500) && ($urandom_range(0, 3) != 0);
      push_payload = $urandom;
      pop_ready = ($urandom_range(0, 2) != 0);
      stalled = pop_valid && !pop_ready;
      held = pop_payload;
      if (pop_valid && pop_ready) popped++;
      if (push_valid && push_ready) pushed++;
      cycle();
    end
    push_valid = 1'b0;
    pop_ready = 1'b0;
    check("stall_total", popped, 500);

    // Flush with five entries held and a read in flight.
    for (int i = 0; i < 5; i++) begin
      push_valid = 1'b1;
      push_payload = 32'hF0 + WIDTH'(i);
      cycle();
    end
    push_valid = 1'b0;
    cycle();
    cycle();
    check("preflush_occ", occupancy, 5);
    flush = 1'b1;
    pop_ready = 1'b1;
    cycle();
    flush = 1'b0;
    pop_ready = 1'b0;
    check("flush_occ", occupancy, 0);
    check("flush_pop_valid", pop_valid, 0);
    cycle();
    check("flush_stale_valid", pop_valid, 0);
    push_valid = 1'b1;
    push_payload = 32'h55;
    cycle();
    push_valid = 1'b0;
    for (int g = 0; g < 10 && !pop_valid; g++) cycle();
    check("flush_next_valid", pop_valid, 1);
    check("flush_next_payload", pop_payload, 32'h55);
    pop_ready = 1'b1;
    cycle();
    pop_ready = 1'b0;

    // Three fill/drain rounds to carry pointers across the wrap.
    for (int r = 0; r < 3; r++) begin
      exp_vals.delete();
      for (int i = 0; i < 8; i++) begin
        push_valid = 1'b1;
        push_payload = $urandom;
        exp_vals.push_back(push_payload);
        cycle();
      end
      push_valid = 1'b0;
      check("wrap_full_occ", occupancy, 8);
      pop_ready = 1'b1;
      got.delete();
      for (int g = 0; g < 40 && got.size() < 8; g++) begin
        if (pop_valid) got.push_back(pop_payload);
        cycle();
      end
      pop_ready = 1'b0;
      check("wrap_count", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++) check("wrap_data", got[i], exp_vals[i]);
    end

    // Reset in the middle of traffic.
    for (int g = 0; g < 20; g++) begin
      push_valid = ($urandom_range(0, 1) != 0);
      push_payload = $urandom;
      pop_ready = ($urandom_range(0, 3) == 0);
      cycle();
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    push_valid = 1'b0;
    pop_ready = 1'b0;
    check("midreset_occ", occupancy, 0);
    check("midreset_pop_valid", pop_valid, 0);
    check("midreset_push_ready", push_ready, 1);
    push_valid = 1'b1;
    push_payload = 32'h1234;
    pop_ready = 1'b1;
    cycle();
    push_valid = 1'b0;
    repeat (4) cycle();
    check("midreset_drained", occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
